// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice processes an operand pair LSB first, WIDTH cycles per add.
// Optional subtract mode (sub port, a - b) is compiled in when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_sum_bit;
    logic             w_carry;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    // A start request is only honoured outside RUN, so an operation in flight cannot be disturbed.
    assign w_accept   = (r_state != RUN) && start;
    assign w_last     = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    assign w_sum_bit  = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry    = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_carry);
    assign w_res_next = {w_sum_bit, r_res};

`ifdef SERIAL_ADDER_SUB_EN
    // a - b is computed as a + ~b + 1; cin is ignored when subtracting.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = start ? RUN : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= w_res_next[WIDTH-1:1];
            r_carry <= w_carry;
            r_cnt   <= r_cnt + CW'(1);
            // On the MSB slice r_carry is the carry into bit WIDTH-1 and w_carry the carry out.
            if (w_last) begin
                r_s    <= w_res_next;
                r_cout <= w_carry;
                r_ovf  <= r_carry ^ w_carry;
            end
        end
    end

    assign s        = r_s;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): arithmetic reference model plus directed vectors.
// Subtract vectors are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             cin   = 1'b0;
    logic             sub   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             overflow;

    int n_vec = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .s        (s),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start yields a result WIDTH edges later, computed arithmetically.
    int               m_run  = 0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_s    = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf  = 1'b0;
    logic [WIDTH-1:0] p_s;
    logic             p_cout;
    logic             p_ovf;
    logic [WIDTH-1:0] m_bb;
    logic             m_c;
    logic [WIDTH:0]   m_tot;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run  = 0;
            m_done = 1'b0;
            m_s    = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_run > 0) begin
            m_run--;
            m_done = 1'b0;
            if (m_run == 0) begin
                m_done = 1'b1;
                m_s    = p_s;
                m_cout = p_cout;
                m_ovf  = p_ovf;
            end
        end else if (start) begin
            m_bb   = sub ? ~b : b;
            m_c    = sub ? 1'b1 : cin;
            m_tot  = {1'b0, a} + {1'b0, m_bb} + {{WIDTH{1'b0}}, m_c};
            p_s    = m_tot[WIDTH-1:0];
            p_cout = m_tot[WIDTH];
            p_ovf  = (a[WIDTH-1] == m_bb[WIDTH-1]) && (m_tot[WIDTH-1] != a[WIDTH-1]);
            m_run  = WIDTH;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", busy, m_run > 0);
            check("done", done, m_done);
            if (m_run == 0) begin
                check("s", s, m_s);
                check("cout", cout, m_cout);
                check("overflow", overflow, m_ovf);
            end
        end
    end

    // Issue one operation, scramble the inputs during RUN, and measure latency and busy cycles.
    task automatic op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                      input logic op_c, input logic op_sub, output int lat, output int nbusy);
        @(negedge clk);
        a = op_a; b = op_b; cin = op_c; sub = op_sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~op_a; b = ~op_b; cin = ~op_c; sub = ~op_sub;
        lat   = 1;
        nbusy = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            nbusy += busy ? 1 : 0;
        end
        sub = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        int nb;
        int n;
        int ndone;
        int t1;
        int t2;
        int busy10;
        logic [WIDTH-1:0] s_at_done;
        logic [WIDTH-1:0] s1;
        logic [WIDTH-1:0] s2;

        #1;
        check("rst_s", s, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        op(8'h0F, 8'h01, 1'b0, 1'b0, lat, nb);
        check("v1_latency", lat, 9);
        check("v1_busy_cycles", nb, 8);
        check("v1_s", s, 8'h10);
        check("v1_cout", cout, 1'b0);
        check("v1_ovf", overflow, 1'b0);
        @(negedge clk);
        check("v1_done_single", done, 1'b0);

        op(8'hFF, 8'h01, 1'b0, 1'b0, lat, nb);
        check("v2_s", s, 8'h00);
        check("v2_cout", cout, 1'b1);
        check("v2_ovf", overflow, 1'b0);

        op(8'h7F, 8'h01, 1'b0, 1'b0, lat, nb);
        check("v3_s", s, 8'h80);
        check("v3_cout", cout, 1'b0);
        check("v3_ovf", overflow, 1'b1);

        // Start pulsed again mid-RUN must be ignored.
        @(negedge clk);
        a = 8'h00; b = 8'h00; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; ndone = 0; t1 = 0; s_at_done = '0;
        while (n < 15) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                a = 8'hAA; b = 8'hAA; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                t1 = n;
                s_at_done = s;
            end
        end
        check("v4_done_count", ndone, 1);
        check("v4_latency", t1, 9);
        check("v4_s", s_at_done, 8'h01);
        check("v4_s_held", s, 8'h01);

        // Asynchronous reset four cycles into RUN.
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("v5_rst_s", s, 8'h00);
        check("v5_rst_busy", busy, 1'b0);
        check("v5_rst_done", done, 1'b0);
        check("v5_rst_cout", cout, 1'b0);
        check("v5_rst_ovf", overflow, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("v5_no_done", ndone, 0);
        op(8'h03, 8'h04, 1'b0, 1'b0, lat, nb);
        check("v5_latency", lat, 9);
        check("v5_s", s, 8'h07);

        // Start held high across DONE: back-to-back operations.
        @(negedge clk);
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h10; b = 8'h20;
        n = 1; t1 = 0; t2 = 0; s1 = '0; s2 = '0; busy10 = 0;
        while (n < 22) begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                start  = 1'b0;
                busy10 = busy ? 1 : 0;
            end
            if (done) begin
                if (t1 == 0) begin
                    t1 = n; s1 = s;
                end else begin
                    t2 = n; s2 = s;
                end
            end
        end
        check("v6_first_done", t1, 9);
        check("v6_first_s", s1, 8'h03);
        check("v6_no_idle_gap", busy10, 1);
        check("v6_done_spacing", t2 - t1, 9);
        check("v6_second_s", s2, 8'h30);

`ifdef SERIAL_ADDER_SUB_EN
        op(8'h05, 8'h07, 1'b0, 1'b1, lat, nb);
        check("sub1_s", s, 8'hFE);
        check("sub1_cout", cout, 1'b0);
        check("sub1_ovf", overflow, 1'b0);
        op(8'h80, 8'h01, 1'b1, 1'b1, lat, nb);
        check("sub2_s", s, 8'h7F);
        check("sub2_cout", cout, 1'b1);
        check("sub2_ovf", overflow, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
